// File: rtl/bmult_pkg.sv
// Shared types, constants and helpers for the 6x6 radix-4 Booth multiplier.
// Pure declarations: no latency, no flow control.
// Nothing here holds state, so there is no backpressure.
package bmult_pkg;

    localparam int BM_WIDTH  = 6;
    localparam int BM_PWIDTH = 12;
    localparam int BM_NPP    = 4;
    localparam int BM_ROWW   = 10;

    // Constant bit 8 cancels the leading-one sign-extension prefixes of all rows, modulo 2^12.
    localparam int BM_SEXT_BIT = 8;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    typedef logic [BM_ROWW-1:0] pp_row_t;

    // Radix-4 recoding of the window {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] w);
        booth_digit_t d;
        d.neg = w[2];
        d.one = w[1] ^ w[0];
        d.two = (w[2] & ~w[1] & ~w[0]) | (~w[2] & w[1] & w[0]);
        return d;
    endfunction

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/bmult_booth_pp.sv
// One Booth partial-product row: the multiplicand times a digit in {-2..+2}, sign-extension prefix included.
// Latency 0: purely combinational.
// No backpressure: it consumes its inputs every cycle.
module bmult_booth_pp
    import bmult_pkg::*;
(
    input  logic [2:0]          window,
    input  logic [BM_WIDTH-1:0] a,
    output pp_row_t             row,
    output logic                neg
);

    booth_digit_t dig;
    logic [7:0]   mag;
    logic [7:0]   pp;

    assign dig = booth_decode(window);

    always_comb begin
        mag = '0;
        if (dig.one) begin
            mag = {2'b00, a};
        end else if (dig.two) begin
            mag = {1'b0, a, 1'b0};
        end
        // Ones' complement here; the +1 is injected into the tree at this row's LSB.
        pp = dig.neg ? ~mag : mag;
    end

    // The sign of pp is exactly dig.neg, because mag never exceeds 126.
    assign row = {1'b1, ~dig.neg, pp};
    assign neg = dig.neg;

endmodule

// File: rtl/bmult_6x6_pipe.sv
// Unsigned 6x6 multiplier: Booth rows, 4:2 and 3:2 compression, then a CPA into the registered product P.
// Latency is 1 clock, or 2 when BMULT_INPUT_REG_EN adds the operand registers.
// No backpressure: it accepts one operand pair every cycle.
module bmult_6x6_pipe
    import bmult_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int PWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic [PWIDTH-1:0] P
);

    typedef logic [BM_PWIDTH+3:0] wide_t;

    logic [BM_WIDTH-1:0] op_a;
    logic [BM_WIDTH-1:0] op_b;

`ifdef BMULT_INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
        end else begin
            op_a <= A;
            op_b <= B;
        end
    end
`else
    assign op_a = A;
    assign op_b = B;
`endif

    // Zero-extend B to 8 bits and append the implicit b[-1] = 0.
    logic [2*BM_NPP:0]   b_ext;
    pp_row_t             rows [BM_NPP];
    logic [BM_NPP-1:0]   negs;

    assign b_ext = {2'b00, op_b, 1'b0};

    for (genvar i = 0; i < BM_NPP; i++) begin : g_pp
        bmult_booth_pp u_pp (
            .window (b_ext[2*i+2 : 2*i]),
            .a      (op_a),
            .row    (rows[i]),
            .neg    (negs[i])
        );
    end

    logic [BM_PWIDTH-1:0] pp_op [BM_NPP];
    logic [BM_PWIDTH-1:0] inj;

    // Rows are weighted by 4^i. Bits at and above 2^12 fall away because the result is taken modulo 2^12.
    always_comb begin
        for (int i = 0; i < BM_NPP; i++) begin
            pp_op[i] = BM_PWIDTH'(wide_t'(rows[i]) << (2 * i));
        end
    end

    always_comb begin
        inj = '0;
        inj[BM_SEXT_BIT] = 1'b1;
        for (int i = 0; i < BM_NPP; i++) begin
            inj[2*i] = negs[i];
        end
    end

    logic [BM_PWIDTH-1:0] s42, c42;

    // Bit-level 4:2 compressor row; the lateral carry cy ripples only a single bit position.
    always_comb begin
        logic cy;
        logic t;
        cy  = 1'b0;
        t   = 1'b0;
        s42 = '0;
        c42 = '0;
        for (int i = 0; i < BM_PWIDTH; i++) begin
            t      = pp_op[0][i] ^ pp_op[1][i] ^ pp_op[2][i];
            s42[i] = t ^ pp_op[3][i] ^ cy;
            c42[i] = maj(t, pp_op[3][i], cy);
            cy     = maj(pp_op[0][i], pp_op[1][i], pp_op[2][i]);
        end
    end

    logic [BM_PWIDTH-1:0] c42_sh, s32, c32, prod;

    assign c42_sh = c42 << 1;

    // The 3:2 stage folds in the negate +1s and the sign-extension constant.
    assign s32  = s42 ^ c42_sh ^ inj;
    assign c32  = (s42 & c42_sh) | (s42 & inj) | (c42_sh & inj);
    assign prod = s32 + (c32 << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P <= '0;
        end else begin
            P <= prod;
        end
    end

endmodule

// File: tb/tb_bmult_6x6_pipe.sv
// Directed-vector and random-stream bench for bmult_6x6_pipe.
// Building with BMULT_INPUT_REG_EN defined makes the expected latency 2 cycles.
module tb_bmult_6x6_pipe;

`ifdef BMULT_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  A;
    logic [5:0]  B;
    logic [11:0] P;

    int checks = 0;
    int errors = 0;

    bmult_6x6_pipe #(.WIDTH(6), .PWIDTH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .P     (P)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] p;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: P=%h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int unsigned ai;
        int unsigned bi;
        logic [11:0] m_in;
        logic [11:0] m_p;

        vecs[0] = '{"a0_b63",   6'd0,  6'd63, 12'h000};
        vecs[1] = '{"a63_b0",   6'd63, 6'd0,  12'h000};
        vecs[2] = '{"a1_b63",   6'd1,  6'd63, 12'h03F};
        vecs[3] = '{"a63_b63",  6'd63, 6'd63, 12'hF81};
        vecs[4] = '{"a32_b32",  6'd32, 6'd32, 12'h400};
        vecs[5] = '{"booth_m2", 6'd63, 6'd42, 12'hA56};
        vecs[6] = '{"booth_m1", 6'd37, 6'd27, 12'h3E7};

        // Held in reset with the operands toggling.
        rst_n = 1'b0;
        A = 6'd5;
        B = 6'd7;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", P, 12'h000);
            A = (A == 6'd5) ? 6'd7 : 6'd5;
            B = (B == 6'd7) ? 6'd5 : 6'd7;
        end

        // Release reset: the first product appears after LAT edges.
        A = 6'd3;
        B = 6'd5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_edge1", P, (LAT == 1) ? 12'd15 : 12'd0);
        @(posedge clk);
        #1;
        check("post_reset_edge2", P, 12'd15);

        // Single product with an exact latency check.
        A = 6'h2A;
        B = 6'h15;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("latency_prev", P, 12'd15);
        @(posedge clk);
        #1;
        check("single_2a_15", P, 12'h372);

        for (int i = 0; i < 7; i++) begin
            A = vecs[i].a;
            B = vecs[i].b;
            repeat (LAT) @(posedge clk);
            #1;
            check(vecs[i].name, P, vecs[i].p);
        end

        // Flush with zero operands so the model starts from a known state.
        A = 6'd0;
        B = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        m_in = 12'd0;
        m_p  = 12'd0;
        for (int n = 0; n < 20000; n++) begin
            ai = $urandom_range(0, 63);
            bi = $urandom_range(0, 63);
            A = 6'(ai);
            B = 6'(bi);
            @(posedge clk);
            if (LAT == 2) begin
                m_p  = m_in;
                m_in = 12'(ai * bi);
            end else begin
                m_p = 12'(ai * bi);
            end
            #1;
            check("stream", P, m_p);
        end

        // Reset in the middle of operation clears P with no clock edge.
        A = 6'd63;
        B = 6'd63;
        repeat (LAT) @(posedge clk);
        #1;
        check("pre_midreset", P, 12'hF81);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", P, 12'h000);
        @(posedge clk);
        #1;
        check("midreset_hold", P, 12'h000);
        A = 6'd9;
        B = 6'd9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_rel_edge1", P, (LAT == 1) ? 12'd81 : 12'd0);
        @(posedge clk);
        #1;
        check("midreset_rel_edge2", P, 12'd81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
